// File: rtl/prio_bus_arbiter_if.sv
// prio_bus_arbiter_if: request/grant bundle between requesting engines and the bus arbiter
interface prio_bus_arbiter_if;
   logic       EI;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       GS;
   logic       EO;
   logic       timeout;
   modport master (output EI, req, input gnt, gnt_id, gnt_valid, GS, EO, timeout);
   modport slave (input EI, req, output gnt, gnt_id, gnt_valid, GS, EO, timeout);
endinterface

// File: rtl/prio_bus_arbiter.sv
// prio_bus_arbiter: 8-requester arbiter with CD4532-style priority, grant hold-timeout and GAP turnaround.
// Define PRIO_ARB_ROTATE_EN for rotating priority (last winner becomes lowest priority).
module prio_bus_arbiter #(
   parameter int TIMEOUT = 16
) (
   input logic clk,
   input logic rst,
   prio_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
   localparam logic [7:0] TLIM = 8'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
   state_t state, state_n;
   logic [7:0] blk, blk_n, cnt, cnt_n, gnt_n, cand;
   logic [2:0] id_n, w;
   logic valid_n, to_n, hit;
   assign cand = bus.req & ~blk;
   assign hit = |cand;
`ifdef PRIO_ARB_ROTATE_EN
   logic [2:0] last_id;
   logic [2:0] k;
   // smallest distance below last_id wins; last_id itself comes last
   always_comb begin
      w = '0;
      k = '0;
      for (int i = 8; i >= 1; i--) begin
         k = last_id - 3'(i);
         if (cand[k]) w = k;
      end
   end
   always_ff @(posedge clk)
      if (rst) last_id <= '0;
      else if (state == IDLE && bus.EI && hit) last_id <= w;
`else
   always_comb begin
      w = '0;
      for (int i = 0; i < 8; i++) if (cand[i]) w = 3'(i);
   end
`endif
   always_comb begin
      state_n = state;
      gnt_n = bus.gnt;
      id_n = bus.gnt_id;
      valid_n = bus.gnt_valid;
      cnt_n = cnt;
      to_n = 1'b0;
      blk_n = blk & bus.req;
      case (state)
         IDLE:
            if (bus.EI && hit) begin
               state_n = BUSY;
               gnt_n = 8'b1 << w;
               id_n = w;
               valid_n = 1'b1;
               cnt_n = '0;
            end
         BUSY:
            if (!bus.req[bus.gnt_id] || (TIMEOUT != 0 && cnt == TLIM)) begin
               state_n = GAP;
               gnt_n = '0;
               id_n = '0;
               valid_n = 1'b0;
               // a forced revoke blocks the owner until it drops its request
               if (bus.req[bus.gnt_id]) begin
                  to_n = 1'b1;
                  blk_n = blk_n | (8'b1 << bus.gnt_id);
               end
            end else cnt_n = cnt == 8'hff ? cnt : cnt + 8'd1;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         blk <= '0;
         cnt <= '0;
         bus.gnt <= '0;
         bus.gnt_id <= '0;
         bus.gnt_valid <= 1'b0;
         bus.GS <= 1'b0;
         bus.EO <= 1'b0;
         bus.timeout <= 1'b0;
      end else begin
         state <= state_n;
         blk <= blk_n;
         cnt <= cnt_n;
         bus.gnt <= gnt_n;
         bus.gnt_id <= id_n;
         bus.gnt_valid <= valid_n;
         bus.GS <= bus.EI && hit;
         bus.EO <= bus.EI && !hit;
         bus.timeout <= to_n;
      end
endmodule

// File: doc/prio_bus_arbiter.md
# prio_bus_arbiter

- Sequential 8-requester arbiter sharing one bus or resource.
- Uses CD4532-style priority encoding:
  - I7 is highest priority.
  - An enable input, a group-select output and an enable-out output behave like the encoder8_3 EI/GS/EO pins.
- Adds grant locking, a hold-timeout and an optional rotating-priority mode.
- Sits between the requesting engines and the shared datapath, driving its select lines from `gnt_id`.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles a grant may be held. 0 disables the timeout. Legal range 0..255.

Ports:
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `EI` in 1: arbitration enable. Low blocks new grants but does not revoke an existing grant.
- `req` in 8: request lines, bit k = requester k. Level-sensitive.
- `gnt` in/out: `gnt` out 8: one-hot grant, registered.
- `gnt_id` out 3: binary index of the current owner. Valid only while `gnt_valid`=1, 0 otherwise.
- `gnt_valid` out 1: a grant is active.
- `GS` out 1: registered; high when EI=1 and any unmasked `req` bit is set.
- `EO` out 1: registered; high when EI=1 and no unmasked `req` bit is set.
- `timeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- FSM states:
  - IDLE: no owner.
  - BUSY: owner holds the bus.
  - GAP: mandatory one-cycle turnaround.
- IDLE:
  - If EI=1 and `req & ~blk` is nonzero, the selected index w is registered: `gnt`=1<<w, `gnt_id`=w, `gnt_valid`=1, hold counter cleared, next state BUSY.
  - Otherwise the FSM stays in IDLE.
- BUSY, evaluated each edge:
  - If `req[gnt_id]`=0: release. `gnt` is cleared, next state GAP.
  - Else if TIMEOUT≠0 and the counter reaches TIMEOUT−1: revoke. `gnt` is cleared, `timeout`=1 for one cycle, `blk[gnt_id]` is set, next state GAP.
  - Otherwise the counter increments; it saturates at 255.
- GAP: always goes to IDLE. No grant is issued in GAP.
- Block mask `blk[7:0]`:
  - Bit k clears on any edge where `req[k]`=0.
  - A revoked requester must drop its request before it can win again.
- Priority selection (fixed, macro absent): highest set bit of `req & ~blk` wins. I7 beats I6, and so on down to I0.
- Winner/`gnt_id` encoding: the same 3-bit binary as encoder8_3 Y for the winning line.
- EI transitions:
  - EI falling while in BUSY: the grant continues until release or timeout.
  - EI low while in IDLE: no grant is issued, and GS=0, EO=0.
- Simultaneous release and new requests: never granted in the same cycle; GAP always intervenes.
- A request bit dropping while in IDLE: it is not granted; requests are sampled only at the IDLE edge.

## Timing
- Reset values:
  - `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `GS`=0, `EO`=0, `timeout`=0.
  - state=IDLE, `blk`=0, counter=0, `last_id`=0.
- Reset asserted mid-grant: all of the above take effect at the next edge; there is no completion of the current grant.
- Grant latency: a request seen at edge N in IDLE gives `gnt` high after edge N (one cycle).
- Release latency: `req[owner]` low at edge N gives `gnt` low after edge N. The earliest next grant follows edge N+2.
- Timeout: with `gnt` first high after edge G, the revoke occurs at edge G+TIMEOUT. The owner therefore holds exactly TIMEOUT cycles, and `timeout` is high during the following cycle.
- GS and EO are registered every cycle, including in BUSY. They reflect requests at the previous edge.

## Configuration
- Macro: `PRIO_ARB_ROTATE_EN`.
- Defined: rotating priority.
  - Register `last_id` is updated to w on every grant.
  - The search starts at `last_id`−1 and proceeds downward, wrapping 0→7; `last_id` itself is lowest priority.
  - After reset, `last_id`=0, so the first search order is 7..0, identical to fixed priority.
- Undefined: fixed priority (I7 highest); `last_id` is not implemented.
- Timing and FSM are identical in both modes.

## Test plan
- Reset then EI=1, `req`=8'b0111_1101 → after 1 cycle `gnt`=8'b0100_0000, `gnt_id`=6, GS=1, EO=0.
- EI=0, `req`=8'b1111_1111 → `gnt_valid` stays 0, GS=0, EO=0. Raise EI → `gnt_id`=7 next cycle.
- Owner 7 drops `req[7]` while `req`=8'b0000_0011 → `gnt`=0 for two cycles (release, GAP), then `gnt_id`=1.
- TIMEOUT=4, `req[2]` held high → `gnt[2]` high exactly 4 cycles, then one `timeout` pulse. Requester 2 is not regranted until `req[2]` toggles low.
- With `PRIO_ARB_ROTATE_EN`, all `req` held high and each owner releasing after 1 cycle → grant order 7,6,5,4,3,2,1,0,7.
- Assert `rst` while `gnt_valid`=1 → all outputs 0 after the next edge, and the next grant follows fixed order from 7.
